daq_capture_ctrl: RTL and testbench

Trigger-driven acquisition sequencer between the ADC read path and the async CDC FIFO write port. It replaces the free-running FIFO write with an armed, triggered capture of a fixed number of decimated samples. Software-facing control (arm/abort/config) and status are synchronous to the ADC clock domain.

---
 rtl/daq_capture_ctrl.sv | 171 +++++++++++++++++
 tb/tb_daq_capture_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_capture_ctrl.sv
`timescale 1ns/1ps
// Trigger-driven capture sequencer: arms on request, waits for a trigger on decimated
// ADC samples, then forwards a fixed number of samples to the CDC FIFO write port.
module daq_capture_ctrl #(
  parameter int INT_DATA_WIDTH  = 10,
  parameter int INT_FIFO_WIDTH  = 32,
  parameter int INT_LEN_WIDTH   = 16,
  parameter int INT_DECIM_WIDTH = 8
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic [INT_DATA_WIDTH-1:0]  in_data,
  input  logic                       in_valid,
  input  logic                       in_arm,
  input  logic                       in_abort,
  input  logic [1:0]                 in_trig_src,
  input  logic [INT_DATA_WIDTH-1:0]  in_trig_level,
  input  logic                       in_ext_trig,
  input  logic [INT_DECIM_WIDTH-1:0] in_decim,
  input  logic [INT_LEN_WIDTH-1:0]   in_post_len,
  input  logic                       in_fifo_ready,
  output logic [INT_FIFO_WIDTH-1:0]  out_fifo_data,
  output logic                       out_fifo_valid,
  output logic [1:0]                 out_state,
  output logic                       out_busy,
  output logic                       out_done,
  output logic                       out_trig_pulse,
  output logic                       out_overflow,
  output logic [INT_LEN_WIDTH-1:0]   out_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0]                        src_l;
  logic signed [INT_DATA_WIDTH-1:0]  level_l;
  logic [INT_DECIM_WIDTH-1:0]        decim_l;
  logic [INT_LEN_WIDTH-1:0]          len_l;
  logic [INT_DECIM_WIDTH-1:0]        decim_cnt;
  logic signed [INT_DATA_WIDTH-1:0]  prev_smp;
  logic signed [INT_DATA_WIDTH-1:0]  cur_smp;
  logic                              prev_vld;
  logic                              ext_prev;
  logic                              ext_pend;

  logic                              active;
  logic                              stroke;
  logic                              arm_ok;
  logic                              ext_rise;
  logic                              src_hit;
  logic                              trig_hit;
  logic                              cap_stroke;
  logic                              last;
  logic [INT_LEN_WIDTH-1:0]          cnt_nxt;

  function automatic logic [INT_FIFO_WIDTH-1:0] pack_word(
    input logic signed [INT_DATA_WIDTH-1:0] smp,
    input logic                             mark
  );
    logic [INT_FIFO_WIDTH-1:0] w;
    w = '0;
    w[INT_DATA_WIDTH-1:0] = smp;
    w[INT_FIFO_WIDTH-1]   = mark;
    return w;
  endfunction

  assign cur_smp   = $signed(in_data);
  assign out_state = state;
  assign out_busy  = (state == S_ARMED) || (state == S_CAPTURE);
  assign out_done  = (state == S_DONE);

  always_comb begin
    active     = (state == S_ARMED) || (state == S_CAPTURE);
    stroke     = active && in_valid && (decim_cnt == decim_l);
    arm_ok     = in_arm && !in_abort && ((state == S_IDLE) || (state == S_DONE));
    ext_rise   = in_ext_trig && !ext_prev;
    src_hit    = 1'b0;
    case (src_l)
      2'd0:    src_hit = prev_vld && (prev_smp < level_l) && (cur_smp >= level_l);
      2'd1:    src_hit = prev_vld && (prev_smp > level_l) && (cur_smp <= level_l);
      2'd2:    src_hit = ext_pend;
      default: src_hit = 1'b1;
    endcase
    trig_hit   = stroke && (state == S_ARMED) && src_hit;
    // abort wins over any stroke in the same cycle, so nothing is written
    cap_stroke = !in_abort && (trig_hit || (stroke && (state == S_CAPTURE)));
    cnt_nxt    = out_count + 1'b1;
    last       = (cnt_nxt == len_l);

    state_nxt  = state;
    if (in_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (in_arm) state_nxt = S_ARMED;
        S_ARMED:        if (trig_hit) state_nxt = last ? S_DONE : S_CAPTURE;
        S_CAPTURE:      if (stroke && last) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // config latch, decimation phase and trigger history
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      src_l     <= 2'd0;
      level_l   <= '0;
      decim_l   <= '0;
      len_l     <= '0;
      decim_cnt <= '0;
      prev_smp  <= '0;
      prev_vld  <= 1'b0;
      ext_prev  <= 1'b0;
      ext_pend  <= 1'b0;
    end else begin
      ext_prev <= in_ext_trig;
      if (arm_ok) begin
        src_l     <= in_trig_src;
        level_l   <= $signed(in_trig_level);
        decim_l   <= in_decim;
        len_l     <= (in_post_len == '0) ? INT_LEN_WIDTH'(1) : in_post_len;
        decim_cnt <= '0;
        prev_vld  <= 1'b0;
        ext_pend  <= 1'b0;
      end else begin
        if (active && in_valid) decim_cnt <= stroke ? '0 : decim_cnt + 1'b1;
        if (stroke && (state == S_ARMED)) begin
          prev_smp <= cur_smp;
          prev_vld <= 1'b1;
        end
        if (stroke && (state == S_ARMED) && (src_l == 2'd2) && ext_pend) ext_pend <= 1'b0;
        // an edge coinciding with a consuming stroke re-arms for the next stroke
        if ((state == S_ARMED) && ext_rise) ext_pend <= 1'b1;
      end
    end
  end

  // stage p1: registered FIFO write, trigger pulse and capture status
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_fifo_valid <= 1'b0;
      out_fifo_data  <= '0;
      out_trig_pulse <= 1'b0;
      out_overflow   <= 1'b0;
      out_count      <= '0;
    end else begin
      out_fifo_valid <= cap_stroke && in_fifo_ready;
      out_trig_pulse <= trig_hit && !in_abort;
      if (cap_stroke && in_fifo_ready) out_fifo_data <= pack_word(cur_smp, trig_hit);
      if (arm_ok) begin
        out_count    <= '0;
        out_overflow <= 1'b0;
      end else if (cap_stroke) begin
        out_count <= cnt_nxt;
        if (!in_fifo_ready) out_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_daq_capture_ctrl.sv
`timescale 1ns/1ps
// Bench for daq_capture_ctrl: directed vector table, corner sequences and a randomized
// run, all compared every cycle against a sample-counting reference model.
module tb_daq_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_arm;
  logic        in_abort;
  logic [1:0]  in_trig_src;
  logic [9:0]  in_trig_level;
  logic        in_ext_trig;
  logic [7:0]  in_decim;
  logic [15:0] in_post_len;
  logic        in_fifo_ready;
  logic [31:0] out_fifo_data;
  logic        out_fifo_valid;
  logic [1:0]  out_state;
  logic        out_busy;
  logic        out_done;
  logic        out_trig_pulse;
  logic        out_overflow;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  daq_capture_ctrl #(
    .INT_DATA_WIDTH (10),
    .INT_FIFO_WIDTH (32),
    .INT_LEN_WIDTH  (16),
    .INT_DECIM_WIDTH(8)
  ) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_arm        (in_arm),
    .in_abort      (in_abort),
    .in_trig_src   (in_trig_src),
    .in_trig_level (in_trig_level),
    .in_ext_trig   (in_ext_trig),
    .in_decim      (in_decim),
    .in_post_len   (in_post_len),
    .in_fifo_ready (in_fifo_ready),
    .out_fifo_data (out_fifo_data),
    .out_fifo_valid(out_fifo_valid),
    .out_state     (out_state),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_trig_pulse(out_trig_pulse),
    .out_overflow  (out_overflow),
    .out_count     (out_count)
  );

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  logic [31:0] wq[$];

  // reference model: counts valid samples since arm, keeps every (decim+1)-th one
  int   m_state, m_src, m_level, m_decim, m_len, m_nvalid, m_prev, m_count;
  bit   m_have_prev, m_ext_last, m_pend, m_ovf, e_valid, e_pulse;
  logic [31:0] e_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_src = 0; m_level = 0; m_decim = 0; m_len = 0;
    m_nvalid = 0; m_prev = 0; m_count = 0;
    m_have_prev = 0; m_ext_last = 0; m_pend = 0; m_ovf = 0;
    e_valid = 0; e_pulse = 0; e_data = '0;
  endtask

  task automatic capture(input int cur, input bit mark);
    m_count++;
    if (in_fifo_ready) begin
      e_valid = 1;
      e_data  = {mark, 21'b0, cur[9:0]};
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_step();
    int cur, old;
    bit stroke, rise, trig;
    cur    = int'($signed(in_data));
    old    = m_state;
    e_valid = 0; e_pulse = 0; stroke = 0; trig = 0;
    rise = in_ext_trig && !m_ext_last;
    m_ext_last = in_ext_trig;
    if ((old == 1 || old == 2) && in_valid) begin
      m_nvalid++;
      stroke = (m_nvalid % (m_decim + 1)) == 0;
    end
    if (in_abort) begin
      m_state = 0;
    end else if (old == 0 || old == 3) begin
      if (in_arm) begin
        m_src = int'(in_trig_src);
        m_level = int'($signed(in_trig_level));
        m_decim = int'(in_decim);
        m_len = (in_post_len == 0) ? 1 : int'(in_post_len);
        m_count = 0; m_ovf = 0; m_nvalid = 0; m_have_prev = 0; m_pend = 0;
        m_state = 1;
      end
    end else if (old == 1) begin
      if (stroke) begin
        case (m_src)
          0: trig = m_have_prev && (m_prev < m_level) && (cur >= m_level);
          1: trig = m_have_prev && (m_prev > m_level) && (cur <= m_level);
          2: trig = m_pend;
          default: trig = 1;
        endcase
        if (m_src == 2) m_pend = 0;
        m_prev = cur;
        m_have_prev = 1;
        if (trig) begin
          capture(cur, 1'b1);
          e_pulse = 1;
          m_state = (m_count == m_len) ? 3 : 2;
        end
      end
    end else begin
      if (stroke) begin
        capture(cur, 1'b0);
        if (m_count == m_len) m_state = 3;
      end
    end
    if (old == 1 && rise) m_pend = 1;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("state", 64'(out_state), 64'(m_state));
    chk("count", 64'(out_count), 64'(m_count));
    chk("flags", 64'({out_busy, out_done, out_trig_pulse, out_overflow, out_fifo_valid}),
        64'({(m_state == 1 || m_state == 2), (m_state == 3), e_pulse, m_ovf, e_valid}));
    if (e_valid) chk("data", 64'(out_fifo_data), 64'(e_data));
    if (out_fifo_valid) wq.push_back(out_fifo_data);
    if (out_trig_pulse) pulses++;
  endtask

  task automatic idle_inputs();
    in_data = '0; in_valid = 0; in_arm = 0; in_abort = 0; in_trig_src = '0;
    in_trig_level = '0; in_ext_trig = 0; in_decim = '0; in_post_len = '0; in_fifo_ready = 1;
  endtask

  task automatic arm(input logic [1:0] src, input logic [9:0] lvl, input logic [7:0] dec,
                     input logic [15:0] len);
    wq.delete();
    pulses = 0;
    in_valid = 0; in_arm = 1; in_trig_src = src; in_trig_level = lvl;
    in_decim = dec; in_post_len = len;
    cyc();
    in_arm = 0;
  endtask

  task automatic feed(input logic [9:0] d, input logic rdy);
    in_valid = 1; in_data = d; in_fifo_ready = rdy;
    cyc();
    in_valid = 0; in_fifo_ready = 1;
  endtask

  task automatic do_abort();
    in_abort = 1;
    cyc();
    in_abort = 0;
  endtask

  typedef struct packed {
    logic [1:0]      src;
    logic [9:0]      level;
    logic [7:0]      decim;
    logic [15:0]     len;
    logic            ramp;
    logic [3:0]      nsmp;
    logic [7:0][9:0] smp;
    logic [1:0]      exp_state;
    logic [15:0]     exp_count;
    logic [7:0]      exp_writes;
    logic [1:0]      exp_pulses;
    logic [31:0]     exp_first;
    logic [31:0]     exp_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // samples are listed last-to-first; 10'h3EC=-20, 10'h3FF=-1, 10'h3FB=-5
    tbl[0] = '{src: 2'd3, level: 10'd0, decim: 8'd0, len: 16'd4, ramp: 1'b0, nsmp: 4'd5,
               smp: {10'd0, 10'd0, 10'd0, 10'd9, 10'd8, 10'd7, 10'd6, 10'd5},
               exp_state: 2'd3, exp_count: 16'd4, exp_writes: 8'd4, exp_pulses: 2'd1,
               exp_first: 32'h8000_0005, exp_last: 32'h0000_0008};
    tbl[1] = '{src: 2'd0, level: 10'd100, decim: 8'd0, len: 16'd3, ramp: 1'b0, nsmp: 4'd5,
               smp: {10'd0, 10'd0, 10'd0, 10'd120, 10'd100, 10'd99, 10'd50, 10'h3EC},
               exp_state: 2'd2, exp_count: 16'd2, exp_writes: 8'd2, exp_pulses: 2'd1,
               exp_first: 32'h8000_0064, exp_last: 32'h0000_0078};
    tbl[2] = '{src: 2'd1, level: 10'd0, decim: 8'd0, len: 16'd2, ramp: 1'b0, nsmp: 4'd2,
               smp: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'h3FF, 10'd10},
               exp_state: 2'd2, exp_count: 16'd1, exp_writes: 8'd1, exp_pulses: 2'd1,
               exp_first: 32'h8000_03FF, exp_last: 32'h8000_03FF};
    tbl[3] = '{src: 2'd1, level: 10'h3FB, decim: 8'd0, len: 16'd1, ramp: 1'b0, nsmp: 4'd1,
               smp: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'h3FB},
               exp_state: 2'd1, exp_count: 16'd0, exp_writes: 8'd0, exp_pulses: 2'd0,
               exp_first: 32'h0, exp_last: 32'h0};
    tbl[4] = '{src: 2'd3, level: 10'd0, decim: 8'd2, len: 16'd3, ramp: 1'b1, nsmp: 4'd0,
               smp: '0,
               exp_state: 2'd3, exp_count: 16'd3, exp_writes: 8'd3, exp_pulses: 2'd1,
               exp_first: 32'h8000_0002, exp_last: 32'h0000_0008};

    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(out_state), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_data", 64'(out_fifo_data), 64'd0);
    chk("rst_flags", 64'({out_busy, out_done, out_trig_pulse, out_overflow, out_fifo_valid}), 64'd0);
    rst_n = 1;
    cyc();

    for (int v = 0; v < 5; v++) begin
      int n;
      arm(tbl[v].src, tbl[v].level, tbl[v].decim, tbl[v].len);
      n = tbl[v].ramp ? 21 : int'(tbl[v].nsmp);
      for (int i = 0; i < n; i++) feed(tbl[v].ramp ? 10'(i) : tbl[v].smp[i], 1'b1);
      repeat (3) cyc();
      chk($sformatf("v%0d_state", v), 64'(out_state), 64'(tbl[v].exp_state));
      chk($sformatf("v%0d_count", v), 64'(out_count), 64'(tbl[v].exp_count));
      chk($sformatf("v%0d_writes", v), 64'(wq.size()), 64'(tbl[v].exp_writes));
      chk($sformatf("v%0d_pulses", v), 64'(pulses), 64'(tbl[v].exp_pulses));
      if (tbl[v].exp_writes != 0 && wq.size() != 0) begin
        chk($sformatf("v%0d_first", v), 64'(wq[0]), 64'(tbl[v].exp_first));
        chk($sformatf("v%0d_last", v), 64'(wq[wq.size()-1]), 64'(tbl[v].exp_last));
      end
      do_abort();
    end

    // FIFO not ready on the third capture stroke
    arm(2'd3, 10'd0, 8'd0, 16'd5);
    for (int i = 1; i <= 5; i++) feed(10'(i), (i != 3));
    repeat (2) cyc();
    chk("ovf_writes", 64'(wq.size()), 64'd4);
    chk("ovf_flag", 64'(out_overflow), 64'd1);
    chk("ovf_count", 64'(out_count), 64'd5);
    chk("ovf_state", 64'(out_state), 64'd3);
    arm(2'd3, 10'd0, 8'd0, 16'd2);
    chk("rearm_ovf", 64'(out_overflow), 64'd0);
    chk("rearm_count", 64'(out_count), 64'd0);
    do_abort();

    // abort and arm together mid-capture
    arm(2'd3, 10'd0, 8'd0, 16'd10);
    for (int i = 0; i < 3; i++) feed(10'(40 + i), 1'b1);
    wq.delete();
    in_abort = 1; in_arm = 1; in_valid = 1; in_data = 10'd77;
    cyc();
    in_abort = 0; in_arm = 0;
    chk("abort_state", 64'(out_state), 64'd0);
    for (int i = 0; i < 3; i++) feed(10'(80 + i), 1'b1);
    chk("abort_writes", 64'(wq.size()), 64'd0);
    chk("abort_count", 64'(out_count), 64'd3);

    // asynchronous reset between clock edges during capture
    arm(2'd3, 10'd0, 8'd0, 16'd10);
    feed(10'd11, 1'b1);
    feed(10'd12, 1'b1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_state", 64'(out_state), 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_data", 64'(out_fifo_data), 64'd0);
    chk("arst_flags", 64'({out_busy, out_done, out_trig_pulse, out_overflow, out_fifo_valid}), 64'd0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc();

    for (int c = 0; c < 3000; c++) begin
      in_arm        = ($urandom_range(0, 19) == 0);
      in_abort      = ($urandom_range(0, 79) == 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      in_fifo_ready = ($urandom_range(0, 9) < 8);
      in_data       = 10'($urandom_range(0, 1023));
      in_trig_src   = 2'($urandom_range(0, 3));
      in_trig_level = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) == 0) in_ext_trig = ~in_ext_trig;
      in_decim      = 8'($urandom_range(0, 3));
      in_post_len   = 16'($urandom_range(0, 12));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
